// File: rtl/direct_sink.sv
// Terminating AXI4-Stream sink: drains beats under drain_en control and keeps
// beat/packet/byte statistics, last packet length, last tuser and a tkeep error flag.
module direct_sink #(
  parameter int DATA_WIDTH     = 512,
  parameter int USER_WIDTH     = 64,
  parameter int CNT_WIDTH      = 32,
  parameter int BYTE_CNT_WIDTH = 48,
  parameter int LEN_WIDTH      = 24,
  localparam int KEEP_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      dt_tvalid,
  output logic                      dt_tready,
  input  logic [DATA_WIDTH-1:0]     dt_tdata,
  input  logic [KEEP_WIDTH-1:0]     dt_tkeep,
  input  logic                      dt_tlast,
  input  logic [USER_WIDTH-1:0]     dt_tuser,
  input  logic                      drain_en,
  input  logic                      clear,
  output logic [CNT_WIDTH-1:0]      beat_count,
  output logic [CNT_WIDTH-1:0]      pkt_count,
  output logic [BYTE_CNT_WIDTH-1:0] byte_count,
  output logic [LEN_WIDTH-1:0]      last_pkt_len,
  output logic [USER_WIDTH-1:0]     last_tuser,
  output logic                      in_packet,
  output logic                      keep_err
);

  localparam int POP_W = $clog2(KEEP_WIDTH + 1);

  logic                      init_reg, init_next;
  logic                      ready_reg, ready_next;
  logic [CNT_WIDTH-1:0]      beat_count_reg, beat_count_next;
  logic [CNT_WIDTH-1:0]      pkt_count_reg, pkt_count_next;
  logic [BYTE_CNT_WIDTH-1:0] byte_count_reg, byte_count_next;
  logic [LEN_WIDTH-1:0]      cur_len_reg, cur_len_next;
  logic [LEN_WIDTH-1:0]      last_pkt_len_reg, last_pkt_len_next;
  logic [USER_WIDTH-1:0]     last_tuser_reg, last_tuser_next;
  logic                      in_packet_reg, in_packet_next;
  logic                      keep_err_reg, keep_err_next;

  logic                      accept;
  logic [POP_W-1:0]          pop_sum [KEEP_WIDTH+1];
  logic [POP_W-1:0]          keep_pop;
  logic [KEEP_WIDTH-1:0]     keep_plus1;
  logic                      keep_bad;
  logic                      unused_tdata;

  assign unused_tdata = ^dt_tdata;
  assign accept       = dt_tvalid && ready_reg;

  assign pop_sum[0] = '0;
  generate
    for (genvar gi = 0; gi < KEEP_WIDTH; gi++) begin : g_pop
      assign pop_sum[gi+1] = pop_sum[gi] + POP_W'(dt_tkeep[gi]);
    end
  endgenerate
  assign keep_pop = pop_sum[KEEP_WIDTH];

  // Legal keep is low-justified contiguous ones (2^k-1, k>=1); non-last beats must be full.
  assign keep_plus1 = dt_tkeep + KEEP_WIDTH'(1);
  assign keep_bad   = (dt_tkeep == '0) || ((dt_tkeep & keep_plus1) != '0) ||
                      (!dt_tlast && (dt_tkeep != '1));

  always_comb begin
    init_next  = 1'b1;
    // init_reg holds ready low for the first edge after reset release
    ready_next = drain_en && init_reg;

    beat_count_next   = clear ? '0 : beat_count_reg;
    pkt_count_next    = clear ? '0 : pkt_count_reg;
    byte_count_next   = clear ? '0 : byte_count_reg;
    cur_len_next      = clear ? '0 : cur_len_reg;
    last_pkt_len_next = clear ? '0 : last_pkt_len_reg;
    last_tuser_next   = clear ? '0 : last_tuser_reg;
    in_packet_next    = clear ? 1'b0 : in_packet_reg;
    keep_err_next     = clear ? 1'b0 : keep_err_reg;

    // Accepted beat applies on top of the (possibly cleared) base values
    if (accept) begin
      beat_count_next = beat_count_next + CNT_WIDTH'(1);
      byte_count_next = byte_count_next + BYTE_CNT_WIDTH'(keep_pop);
      cur_len_next    = (in_packet_next ? cur_len_next : '0) + LEN_WIDTH'(keep_pop);
      if (!in_packet_next) begin
        last_tuser_next = dt_tuser;
      end
      if (keep_bad) begin
        keep_err_next = 1'b1;
      end
      if (dt_tlast) begin
        pkt_count_next    = pkt_count_next + CNT_WIDTH'(1);
        last_pkt_len_next = cur_len_next;
        in_packet_next    = 1'b0;
      end else begin
        in_packet_next = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      init_reg         <= 1'b0;
      ready_reg        <= 1'b0;
      beat_count_reg   <= '0;
      pkt_count_reg    <= '0;
      byte_count_reg   <= '0;
      cur_len_reg      <= '0;
      last_pkt_len_reg <= '0;
      last_tuser_reg   <= '0;
      in_packet_reg    <= 1'b0;
      keep_err_reg     <= 1'b0;
    end else begin
      init_reg         <= init_next;
      ready_reg        <= ready_next;
      beat_count_reg   <= beat_count_next;
      pkt_count_reg    <= pkt_count_next;
      byte_count_reg   <= byte_count_next;
      cur_len_reg      <= cur_len_next;
      last_pkt_len_reg <= last_pkt_len_next;
      last_tuser_reg   <= last_tuser_next;
      in_packet_reg    <= in_packet_next;
      keep_err_reg     <= keep_err_next;
    end
  end

  assign dt_tready    = ready_reg;
  assign beat_count   = beat_count_reg;
  assign pkt_count    = pkt_count_reg;
  assign byte_count   = byte_count_reg;
  assign last_pkt_len = last_pkt_len_reg;
  assign last_tuser   = last_tuser_reg;
  assign in_packet    = in_packet_reg;
  assign keep_err     = keep_err_reg;

endmodule

// File: tb/tb_direct_sink.sv
// Scoreboard bench for direct_sink: stimulus queues hand-computed post-beat statistics,
// a monitor pops and compares them after every accepted beat.
module tb_direct_sink;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic         dt_tvalid;
  logic         dt_tready;
  logic [511:0] dt_tdata;
  logic [63:0]  dt_tkeep;
  logic         dt_tlast;
  logic [63:0]  dt_tuser;
  logic         drain_en;
  logic         clear;
  logic [31:0]  beat_count, pkt_count;
  logic [47:0]  byte_count;
  logic [23:0]  last_pkt_len;
  logic [63:0]  last_tuser;
  logic         in_packet, keep_err;

  logic         w_tready;
  logic [3:0]   w_beat_count, w_pkt_count;
  logic [47:0]  w_byte_count;
  logic [23:0]  w_last_pkt_len;
  logic [63:0]  w_last_tuser;
  logic         w_in_packet, w_keep_err;

  always #5 aclk = ~aclk;

  direct_sink u_dut (
    .aclk(aclk), .aresetn(aresetn), .dt_tvalid(dt_tvalid), .dt_tready(dt_tready),
    .dt_tdata(dt_tdata), .dt_tkeep(dt_tkeep), .dt_tlast(dt_tlast), .dt_tuser(dt_tuser),
    .drain_en(drain_en), .clear(clear), .beat_count(beat_count), .pkt_count(pkt_count),
    .byte_count(byte_count), .last_pkt_len(last_pkt_len), .last_tuser(last_tuser),
    .in_packet(in_packet), .keep_err(keep_err)
  );

  // Narrow-counter instance sharing the stimulus, used for the wrap-around check
  direct_sink #(.CNT_WIDTH(4)) u_wrap (
    .aclk(aclk), .aresetn(aresetn), .dt_tvalid(dt_tvalid), .dt_tready(w_tready),
    .dt_tdata(dt_tdata), .dt_tkeep(dt_tkeep), .dt_tlast(dt_tlast), .dt_tuser(dt_tuser),
    .drain_en(drain_en), .clear(clear), .beat_count(w_beat_count), .pkt_count(w_pkt_count),
    .byte_count(w_byte_count), .last_pkt_len(w_last_pkt_len), .last_tuser(w_last_tuser),
    .in_packet(w_in_packet), .keep_err(w_keep_err)
  );

  typedef struct {
    logic [31:0] beat;
    logic [31:0] pkt;
    logic [47:0] bytes;
    logic [23:0] len;
    logic [63:0] tuser;
    logic        inp;
    logic        err;
    logic        chk_w;
    logic [3:0]  wbeat;
    logic [3:0]  wpkt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_pass  = 0;
  int   n_total = 0;
  int   beat_no = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  // Monitor: one line per accepted beat, then compare against the queued expectation
  always @(posedge aclk) begin
    if (aresetn && dt_tvalid && dt_tready) begin
      #1;
      beat_no++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_beat: got beat %0d expected none", beat_no);
      end else begin
        mon_e = exp_q.pop_front();
        $display("beat %0d: beats=%0d pkts=%0d bytes=%0d len=%0d tuser=0x%0h inpkt=%0b kerr=%0b",
                 beat_no, beat_count, pkt_count, byte_count, last_pkt_len, last_tuser,
                 in_packet, keep_err);
        chk("beat_count", 64'(beat_count), 64'(mon_e.beat));
        chk("pkt_count", 64'(pkt_count), 64'(mon_e.pkt));
        chk("byte_count", 64'(byte_count), 64'(mon_e.bytes));
        chk("last_pkt_len", 64'(last_pkt_len), 64'(mon_e.len));
        chk("last_tuser", last_tuser, mon_e.tuser);
        chk("in_packet", 64'(in_packet), 64'(mon_e.inp));
        chk("keep_err", 64'(keep_err), 64'(mon_e.err));
        if (mon_e.chk_w) begin
          chk("wrap_beat_count", 64'(w_beat_count), 64'(mon_e.wbeat));
          chk("wrap_pkt_count", 64'(w_pkt_count), 64'(mon_e.wpkt));
        end
      end
    end
  end

  task automatic drive(input logic [63:0] keep, input logic last, input logic [63:0] user,
                       input logic [31:0] b, input logic [31:0] p, input logic [47:0] by,
                       input logic [23:0] len, input logic [63:0] tu, input logic inp,
                       input logic err, input logic cw = 1'b0, input logic [3:0] wb = 4'd0,
                       input logic [3:0] wp = 4'd0);
    exp_t e;
    e.beat = b; e.pkt = p; e.bytes = by; e.len = len; e.tuser = tu;
    e.inp = inp; e.err = err; e.chk_w = cw; e.wbeat = wb; e.wpkt = wp;
    exp_q.push_back(e);
    dt_tvalid = 1'b1;
    dt_tkeep  = keep;
    dt_tlast  = last;
    dt_tuser  = user;
    dt_tdata  = {8{user}};
  endtask

  task automatic wait_accept();
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge aclk);
      if (dt_tready) got = 1;
    end
    if (!got) begin
      n_total++;
      $display("FAIL accept_timeout: got no handshake expected one within 20 cycles");
    end
    @(negedge aclk);
    dt_tvalid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    clear = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0; dt_tvalid = 1'b0; dt_tdata = '0; dt_tkeep = '0; dt_tlast = 1'b0;
    dt_tuser = '0; drain_en = 1'b1; clear = 1'b0;

    // Reset and idle
    repeat (3) @(negedge aclk);
    chk("rst_tready", 64'(dt_tready), 64'd0);
    chk("rst_beat_count", 64'(beat_count), 64'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("tready_edge1", 64'(dt_tready), 64'd0);
    @(negedge aclk);
    chk("tready_edge2", 64'(dt_tready), 64'd1);
    repeat (2) @(negedge aclk);
    chk("idle_beat_count", 64'(beat_count), 64'd0);
    chk("idle_byte_count", 64'(byte_count), 64'd0);
    chk("idle_in_packet", 64'(in_packet), 64'd0);

    // Back-to-back packets
    drive('1, 0, 64'hA5, 1, 0, 64, 0, 64'hA5, 1, 0);                     wait_accept();
    drive('1, 0, 64'h11, 2, 0, 128, 0, 64'hA5, 1, 0);                    wait_accept();
    drive(64'h0000_0000_0000_FFFF, 1, 64'h22, 3, 1, 144, 144, 64'hA5, 0, 0); wait_accept();
    drive(64'h1, 1, 64'h5A, 4, 2, 145, 1, 64'h5A, 0, 0);                 wait_accept();

    // Malformed tkeep
    pulse_clear();
    drive(64'h5, 1, 64'h77, 1, 1, 2, 2, 64'h77, 0, 1);                   wait_accept();
    drive(64'hFF, 0, 64'h88, 2, 1, 10, 2, 64'h88, 1, 1);                 wait_accept();

    // Clear zeroes everything including the sticky error and packet state
    pulse_clear();
    chk("clr_beat_count", 64'(beat_count), 64'd0);
    chk("clr_keep_err", 64'(keep_err), 64'd0);
    chk("clr_in_packet", 64'(in_packet), 64'd0);
    chk("clr_last_tuser", last_tuser, 64'd0);

    // Backpressure mid-packet
    drive('1, 0, 64'h31, 1, 0, 64, 0, 64'h31, 1, 0);                     wait_accept();
    drive('1, 0, 64'h32, 2, 0, 128, 0, 64'h31, 1, 0);
    drain_en = 1'b0;
    wait_accept();
    drive(64'hFFFF_FFFF, 1, 64'h33, 3, 1, 160, 160, 64'h31, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_tready_low", 64'(dt_tready), 64'd0);
      chk("bp_beat_hold", 64'(beat_count), 64'd2);
      chk("bp_in_packet", 64'(in_packet), 64'd1);
      if (i == 4) drain_en = 1'b1;
      else @(negedge aclk);
    end
    wait_accept();

    // Clear collision with an accepted 64-byte last beat
    drive('1, 1, 64'h42, 1, 1, 64, 64, 64'h42, 0, 0);
    clear = 1'b1;
    wait_accept();
    clear = 1'b0;

    // Wrap-around on the 4-bit counter instance
    pulse_clear();
    for (int i = 0; i < 17; i++) begin
      drive(64'h3, 1, 64'(i), 32'(i + 1), 32'(i + 1), 48'(2 * (i + 1)), 24'd2, 64'(i),
            0, 0, (i >= 15), (i == 15) ? 4'd0 : 4'd1, (i == 15) ? 4'd0 : 4'd1);
      wait_accept();
    end

    // Reset asserted mid-packet returns to reset values immediately
    drive('1, 0, 64'h99, 18, 17, 98, 2, 64'h99, 1, 0);                   wait_accept();
    aresetn = 1'b0;
    #1;
    chk("midrst_in_packet", 64'(in_packet), 64'd0);
    chk("midrst_beat_count", 64'(beat_count), 64'd0);
    chk("midrst_tready", 64'(dt_tready), 64'd0);
    repeat (2) @(negedge aclk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/direct_sink.md
# direct_sink

Terminating AXI4-Stream consumer for the 512-bit middleware stream fabric. It is placed where a kernel-side or network-side stream has no real destination, directly downstream of a stream source, and it drains the stream under software control. While draining it keeps per-stream statistics: beats, packets, bytes and last packet length. It also flags malformed `tkeep` patterns and captures the `tuser` word of the most recent packet for debug.

## Interface
- `DATA_WIDTH`, 512: `tdata` width in bits, a multiple of 8; `KEEP_WIDTH` = `DATA_WIDTH`/8.
- `USER_WIDTH`, 64: `tuser` width.
- `CNT_WIDTH`, 32: width of the beat and packet counters.
- `BYTE_CNT_WIDTH`, 48: width of the byte counter.
- `LEN_WIDTH`, 24: width of the in-progress and last-packet byte-length registers.

- `aclk`  in  1  sole clock; all logic is rising-edge.
- `aresetn`  in  1  asynchronous, active-low reset.
- `dt_tvalid`  in  1  upstream beat valid.
- `dt_tready`  out  1  sink ready; registered.
- `dt_tdata`  in  DATA_WIDTH  payload; ignored, never stored.
- `dt_tkeep`  in  KEEP_WIDTH  byte enables; bit 0 is byte 0.
- `dt_tlast`  in  1  end of packet.
- `dt_tuser`  in  USER_WIDTH  sideband/routing word.
- `drain_en`  in  1  level: 1 = accept beats.
- `clear`  in  1  synchronous single-cycle pulse that zeroes statistics.
- `beat_count`  out  CNT_WIDTH  accepted beats.
- `pkt_count`  out  CNT_WIDTH  accepted beats with `tlast`.
- `byte_count`  out  BYTE_CNT_WIDTH  sum of set `tkeep` bits over accepted beats.
- `last_pkt_len`  out  LEN_WIDTH  byte length of the most recently completed packet.
- `last_tuser`  out  USER_WIDTH  `tuser` of the first beat of the most recently started packet.
- `in_packet`  out  1  1 between a non-last accepted beat and the following accepted `tlast` beat.
- `keep_err`  out  1  sticky malformed-`tkeep` flag.

## Operation
- Handshake: a beat is accepted in a cycle where `dt_tvalid` && `dt_tready`. No data is buffered.
- `dt_tready` is a register. Its next value is `drain_en`, so ready follows `drain_en` one cycle later.
- Per accepted beat, let `n` = popcount(`dt_tkeep`), 0..KEEP_WIDTH:
  - `beat_count` += 1.
  - `byte_count` += `n`.
  - Running length: `cur_len` = (`in_packet` ? `cur_len` : 0) + `n`.
- Packet start: an accepted beat while `in_packet`=0 loads `last_tuser` with `dt_tuser`.
- Packet end, beat with `dt_tlast`=1:
  - `pkt_count` += 1.
  - `last_pkt_len` = `cur_len` including this beat.
  - `in_packet` = 0.
- Continuing packet, beat with `dt_tlast`=0: `in_packet` = 1.
- A single-beat packet does both of the following: loads `last_tuser`, and loads `last_pkt_len` = `n`.
- Arithmetic overflow:
  - All counters wrap modulo 2^width; there is no saturation.
  - `cur_len`/`last_pkt_len` also wrap; they are not flagged.
- `keep_err` is set by any accepted beat where either condition holds:
  - `dt_tkeep` is not of the form 2^k−1 with 1≤k≤KEEP_WIDTH (zero, or non-contiguous, or not low-justified);
  - `dt_tlast`=0 and `dt_tkeep` is not all-ones.
  - The beat is still counted normally.
- `clear` has priority over increments. In the clear cycle:
  - All counters, `last_pkt_len`, `last_tuser`, `keep_err` and `cur_len` go to 0.
  - `in_packet` goes to 0 as well, so a packet in flight restarts its length and `tuser` capture at the next accepted beat.
  - A beat accepted in the same cycle as `clear` then contributes as the first event after clear: counters hold exactly its contribution, and `keep_err` reflects only that beat.
- `drain_en` deasserted mid-packet only backpressures the stream; packet state is kept.

## Timing
- Reset (async assert, synchronous release). All outputs are 0 while `aresetn`=0:
  - `dt_tready`=0 and `in_packet`=0.
  - All counters, `last_pkt_len`, `last_tuser` and `keep_err` = 0.
- `dt_tready`: earliest assertion is the second rising edge after `aresetn` rises with `drain_en`=1.
- Statistics update latency: 1 cycle. Outputs reflect a beat accepted at edge N from edge N onward, i.e. they are registered on the acceptance edge.
- Throughput: one beat per cycle sustained while `drain_en`=1.
- The popcount adder is the critical path; a second pipeline stage is not permitted, since statistics latency is fixed at 1.
- Reset asserted mid-packet: everything returns to reset values immediately. The partial packet is not counted.

## Test plan
- **Reset and idle:** hold `aresetn`=0, then release with `drain_en`=1 → `dt_tready` 0 until the 2nd edge after release, then 1; all statistics stay 0 while `dt_tvalid`=0.
- **Back-to-back packets:** send a 3-beat packet with `tkeep` FF..FF, FF..FF, 0x0000_0000_0000_FFFF, `tuser` 0xA5 on beat 1, followed by a 1-beat packet with `tkeep`=0x1 and `tuser` 0x5A → `beat_count`=4, `pkt_count`=2, `byte_count`=145, `last_pkt_len`=1, `last_tuser`=0x5A, `in_packet`=0, `keep_err`=0.
- **Malformed `tkeep`:** one beat with `tkeep`=0x5 and `tlast`=1, then one beat with `tkeep`=0xFF and `tlast`=0 → `keep_err`=1 after the first beat and stays 1; `byte_count`=10.
- **Backpressure:** drop `drain_en` for 5 cycles mid-packet with `dt_tvalid` held → `dt_tready` is low for 5 cycles, lagging `drain_en` by one; no beats are counted meanwhile; `in_packet` stays 1; the final length is correct.
- **Clear collision:** pulse `clear` on the same edge as an accepted 64-byte `tlast` beat → `beat_count`=1, `pkt_count`=1, `byte_count`=64, `keep_err`=0.
- **Wrap-around:** with `CNT_WIDTH`=4, send 17 single-beat packets → `beat_count`=1, `pkt_count`=1.
